// File: rtl/lfsr_victim_select.sv
// Pseudo-random victim-way selector: LFSR candidate, lock skip, registered handshake response.
// Optional invalid-way priority is built only when LFSR_VICTIM_INVALID_FIRST_EN is defined.

module lfsr #(
  parameter int WIDTH       = 2,
  parameter bit NEEDS_RESET = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] value_o
);

  function automatic logic [7:0] tap_mask(input int w);
    case (w)
      32'd2:   tap_mask = 8'b0000_0011;
      32'd3:   tap_mask = 8'b0000_0110;
      32'd4:   tap_mask = 8'b0000_1100;
      32'd5:   tap_mask = 8'b0001_0100;
      32'd6:   tap_mask = 8'b0011_0000;
      32'd7:   tap_mask = 8'b0110_0000;
      32'd8:   tap_mask = 8'b1011_1000;
      default: tap_mask = 8'b0000_0011;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

  logic [WIDTH-1:0] value_q;
  logic             fb_s;

  // Maximal-length XOR feedback, flipped when the shifted-on bits are zero so the all-zero state is included
  always_comb begin
    fb_s = (^(value_q & TAPS)) ^ (value_q[WIDTH-2:0] == {(WIDTH-1){1'b0}});
  end

  // LFSR state register
  always_ff @(posedge clk_i) begin
    if (rst_i && NEEDS_RESET) begin
      value_q <= {WIDTH{1'b0}};
    end else if (en_i) begin
      value_q <= {value_q[WIDTH-2:0], fb_s};
    end else begin
      value_q <= value_q;
    end
  end

  assign value_o = value_q;

endmodule

module lfsr_victim_select #(
  parameter int WAYS        = 4,
  parameter bit NEEDS_RESET = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [WAYS-1:0]         valid_ways_i,
  input  logic [WAYS-1:0]         locked_ways_i,
  output logic                    ready_o,
  output logic                    victim_valid_o,
  output logic                    victim_none_o,
  output logic [$clog2(WAYS)-1:0] victim_way_o,
  output logic [WAYS-1:0]         victim_oh_o
);

  localparam int W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    idx_q, idx_d;
  logic [WAYS-1:0] lock_q, lock_d;
  logic            valid_q, valid_d;
  logic            none_q, none_d;
  logic [W-1:0]    way_q, way_d;
  logic [WAYS-1:0] oh_q, oh_d;
  logic            accept_s;
  logic [W-1:0]    cand_s;
  logic            inv_hit_s;
  logic [W-1:0]    inv_way_s;

  assign ready_o  = (state_q == IDLE);
  assign accept_s = req_i & ready_o;

  lfsr #(
    .WIDTH       (W),
    .NEEDS_RESET (NEEDS_RESET)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (accept_s),
    .value_o (cand_s)
  );

`ifdef LFSR_VICTIM_INVALID_FIRST_EN
  function automatic logic [W-1:0] lowest_set(input logic [WAYS-1:0] m);
    lowest_set = {W{1'b0}};
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (m[i]) begin
        lowest_set = W'(i);
      end
    end
  endfunction

  assign inv_hit_s = |(~valid_ways_i & ~locked_ways_i);
  assign inv_way_s = lowest_set(~valid_ways_i & ~locked_ways_i);
`else
  // valid_ways_i is folded away so the invalid-priority path does not exist in this build
  assign inv_hit_s = 1'b0 & (|valid_ways_i);
  assign inv_way_s = {W{1'b0}};
`endif

  // Next-state and response selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lock_d  = lock_q;
    way_d   = way_q;
    none_d  = none_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          lock_d = locked_ways_i;
          if (&locked_ways_i) begin
            none_d  = 1'b1;
            way_d   = {W{1'b0}};
            state_d = RESPOND;
          end else if (inv_hit_s) begin
            none_d  = 1'b0;
            way_d   = inv_way_s;
            state_d = RESPOND;
          end else if (!locked_ways_i[cand_s]) begin
            none_d  = 1'b0;
            way_d   = cand_s;
            state_d = RESPOND;
          end else begin
            idx_d   = cand_s + W'(1'b1);
            state_d = SEARCH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (!lock_q[idx_q]) begin
          none_d  = 1'b0;
          way_d   = idx_q;
          state_d = RESPOND;
        end else begin
          idx_d   = idx_q + W'(1'b1);
          state_d = SEARCH;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response outputs are computed alongside the transition into RESPOND so they arrive registered
  always_comb begin
    valid_d = (state_d == RESPOND);
    if (none_d) begin
      oh_d = {WAYS{1'b0}};
    end else begin
      oh_d = {{(WAYS-1){1'b0}}, 1'b1} << way_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= {W{1'b0}};
      lock_q  <= {WAYS{1'b0}};
      valid_q <= 1'b0;
      none_q  <= 1'b0;
      way_q   <= {W{1'b0}};
      oh_q    <= {WAYS{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      none_q  <= none_d;
      way_q   <= way_d;
      oh_q    <= oh_d;
    end
  end

  assign victim_valid_o = valid_q;
  assign victim_none_o  = none_q;
  assign victim_way_o   = way_q;
  assign victim_oh_o    = oh_q;

endmodule

// File: tb/tb_lfsr_victim_select.sv
// Self-checking bench for lfsr_victim_select: 4-way and 8-way instances, vector table,
// hand-written corner sequences and a randomized run against a behavioural model.

module tb_lfsr_victim_select;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, req4, ready4, vv4, vn4;
  logic [3:0] lock4, val4, oh4;
  logic [1:0] vw4;
  logic       rst8, req8, ready8, vv8, vn8;
  logic [7:0] lock8, val8, oh8;
  logic [2:0] vw8;

  int checks = 0;
  int errors = 0;

  lfsr_victim_select #(.WAYS(4), .NEEDS_RESET(1'b1)) u4 (
    .clk_i(clk), .rst_i(rst4), .req_i(req4), .valid_ways_i(val4), .locked_ways_i(lock4),
    .ready_o(ready4), .victim_valid_o(vv4), .victim_none_o(vn4), .victim_way_o(vw4),
    .victim_oh_o(oh4)
  );

  lfsr_victim_select #(.WAYS(8), .NEEDS_RESET(1'b1)) u8 (
    .clk_i(clk), .rst_i(rst8), .req_i(req8), .valid_ways_i(val8), .locked_ways_i(lock8),
    .ready_o(ready8), .victim_valid_o(vv8), .victim_none_o(vn8), .victim_way_o(vw8),
    .victim_oh_o(oh8)
  );

`ifdef LFSR_VICTIM_INVALID_FIRST_EN
  localparam bit INV_FIRST = 1'b1;
`else
  localparam bit INV_FIRST = 1'b0;
`endif

  typedef struct {
    logic [3:0] lock;
    logic [3:0] valid;
    int         way;
    int         lat;
    int         none;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic [7:0] l, input logic [7:0] v);
    if (sel == 4) begin
      req4 = r; lock4 = l[3:0]; val4 = v[3:0];
    end else begin
      req8 = r; lock8 = l; val8 = v;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 4) ? ready4 : ready8;
  endfunction

  function automatic logic get_vv(input int sel);
    return (sel == 4) ? vv4 : vv8;
  endfunction

  task automatic reset_dut(input int sel);
    if (sel == 4) begin rst4 = 1'b1; req4 = 1'b0; end
    else begin rst8 = 1'b1; req8 = 1'b0; end
    repeat (2) @(negedge clk);
    if (sel == 4) rst4 = 1'b0;
    else rst8 = 1'b0;
  endtask

  // Issue one request, follow it to its response, optionally disturbing inputs while it is in flight.
  task automatic do_req(input int sel, input logic [7:0] lock, input logic [7:0] valid,
                        input bit toggle, output int lat, output int way, output int none,
                        output int oh);
    int n;
    n = 0;
    while (get_ready(sel) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'd0, get_ready(sel)}, 32'd1);
    drive(sel, 1'b1, lock, valid);
    lat = 0; way = 0; none = 0; oh = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("ready_low_after_accept", {31'd0, get_ready(sel)}, 32'd0);
      end
      if (get_vv(sel) === 1'b1) begin
        lat  = i;
        way  = (sel == 4) ? int'(vw4) : int'(vw8);
        none = (sel == 4) ? int'(vn4) : int'(vn8);
        oh   = (sel == 4) ? int'(oh4) : int'(oh8);
        break;
      end
      if (toggle) drive(sel, 1'($urandom_range(1)), 8'($urandom), 8'($urandom));
      else drive(sel, 1'b0, lock, valid);
    end
    drive(sel, 1'b0, 8'($urandom), 8'($urandom));
    @(negedge clk);
    chk("valid_single_pulse", {31'd0, get_vv(sel)}, 32'd0);
    chk("ready_after_respond", {31'd0, get_ready(sel)}, 32'd1);
  endtask

  task automatic chk_resp(input string tag, input int lat, input int way, input int none,
                          input int oh, input int e_lat, input int e_way, input int e_none);
    int e_oh;
    e_oh = e_none ? 0 : (1 << e_way);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_way"}, way, e_way);
    chk({tag, "_none"}, none, e_none);
    chk({tag, "_oh"}, oh, e_oh);
  endtask

  initial begin
    vec_t tbl[8];
    int   lfsr4_seq[4];
    int   lat, way, none, oh;
    int   seq_idx, cand, d, e_way, e_lat, e_none;
    logic [3:0] rl, rv, freem;

    lfsr4_seq = '{0, 1, 3, 2};
    tbl[0] = '{4'b0000, 4'b1111, 0, 1, 0};
    tbl[1] = '{4'b0000, 4'b1111, 1, 1, 0};
    tbl[2] = '{4'b1000, 4'b1111, 0, 2, 0};
    tbl[3] = '{4'b0100, 4'b1111, 3, 2, 0};
    tbl[4] = '{4'b1111, 4'b1111, 0, 1, 1};
    tbl[5] = '{4'b1110, 4'b1111, 0, 4, 0};
    tbl[6] = '{4'b0000, 4'b1011, INV_FIRST ? 2 : 3, 1, 0};
    tbl[7] = '{4'b0010, 4'b1101, 2, 1, 0};

    rst4 = 1'b1; req4 = 1'b0; lock4 = 4'd0; val4 = 4'hF;
    rst8 = 1'b1; req8 = 1'b0; lock8 = 8'd0; val8 = 8'hFF;
    repeat (3) @(negedge clk);
    rst4 = 1'b0; rst8 = 1'b0;
    chk("rst_ready4", {31'd0, ready4}, 32'd1);
    chk("rst_valid4", {31'd0, vv4}, 32'd0);
    chk("rst_none4", {31'd0, vn4}, 32'd0);
    chk("rst_way4", {30'd0, vw4}, 32'd0);
    chk("rst_oh4", {28'd0, oh4}, 32'd0);
    chk("rst_ready8", {31'd0, ready8}, 32'd1);
    chk("rst_valid8", {31'd0, vv8}, 32'd0);
    chk("rst_oh8", {24'd0, oh8}, 32'd0);

    // Back-to-back: req held high, responses two cycles apart with ways 0 then 1
    req4 = 1'b1; lock4 = 4'd0; val4 = 4'hF;
    @(negedge clk);
    chk("b2b_first_valid", {31'd0, vv4}, 32'd1);
    chk("b2b_first_way", {30'd0, vw4}, 32'd0);
    @(negedge clk);
    chk("b2b_gap_valid", {31'd0, vv4}, 32'd0);
    chk("b2b_gap_ready", {31'd0, ready4}, 32'd1);
    @(negedge clk);
    req4 = 1'b0;
    chk("b2b_second_valid", {31'd0, vv4}, 32'd1);
    chk("b2b_second_way", {30'd0, vw4}, 32'd1);
    @(negedge clk);

    // Vector table from a fresh reset: candidates walk 0,1,3,2,...
    reset_dut(4);
    for (int i = 0; i < 8; i++) begin
      do_req(4, {4'd0, tbl[i].lock}, {4'd0, tbl[i].valid}, 1'b0, lat, way, none, oh);
      chk_resp($sformatf("tbl%0d", i), lat, way, none, oh, tbl[i].lat, tbl[i].way, tbl[i].none);
    end

    // First request after reset with ways 0 and 1 locked: two search steps
    reset_dut(4);
    do_req(4, 8'h03, 8'h0F, 1'b0, lat, way, none, oh);
    chk_resp("lock0011", lat, way, none, oh, 3, 2, 0);

    // 8-way: everything locked
    reset_dut(8);
    do_req(8, 8'hFF, 8'hFF, 1'b0, lat, way, none, oh);
    chk_resp("all_locked8", lat, way, none, oh, 1, 0, 1);

    // 8-way invalid-way priority versus LFSR candidate (0 right after reset)
    reset_dut(8);
    do_req(8, 8'h04, 8'hF3, 1'b0, lat, way, none, oh);
    chk_resp("inv_first8", lat, way, none, oh, 1, INV_FIRST ? 3 : 0, 0);

    // 8-way: toggling masks mid-search do not change the result (candidate 0, only way 7 free)
    reset_dut(8);
    do_req(8, 8'h7F, 8'hFF, 1'b1, lat, way, none, oh);
    chk_resp("toggle_search8", lat, way, none, oh, 8, 7, 0);

    // 8-way: reset during SEARCH drops the request and clears the LFSR
    reset_dut(8);
    req8 = 1'b1; lock8 = 8'h7F; val8 = 8'hFF;
    @(negedge clk);
    req8 = 1'b0;
    chk("srch_busy", {31'd0, ready8}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      lock8 = 8'($urandom);
      chk("srch_no_valid", {31'd0, vv8}, 32'd0);
    end
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("srch_rst_ready", {31'd0, ready8}, 32'd1);
    chk("srch_rst_valid", {31'd0, vv8}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("srch_dropped", {31'd0, vv8}, 32'd0);
    end
    do_req(8, 8'h00, 8'hFF, 1'b0, lat, way, none, oh);
    chk_resp("after_rst_lfsr0", lat, way, none, oh, 1, 0, 0);

    // Randomized run on the 4-way instance against the selection rules
    reset_dut(4);
    seq_idx = 0;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      rl = 4'($urandom);
      rv = 4'($urandom);
      if ($urandom_range(3) == 0) rl = 4'hF;
      cand = lfsr4_seq[seq_idx];
      seq_idx = (seq_idx + 1) % 4;
      freem = ~rv & ~rl;
      if (rl == 4'hF) begin
        e_none = 1; e_way = 0; e_lat = 1;
      end else if (INV_FIRST && freem != 4'd0) begin
        e_none = 0; e_lat = 1; e_way = 0;
        while (!freem[e_way]) e_way++;
      end else begin
        d = 0;
        while (rl[(cand + d) % 4]) d++;
        e_none = 0; e_way = (cand + d) % 4; e_lat = 1 + d;
      end
      do_req(4, {4'd0, rl}, {4'd0, rv}, 1'b1, lat, way, none, oh);
      chk_resp($sformatf("rand%0d", n), lat, way, none, oh, e_lat, e_way, e_none);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_victim_select.md
# lfsr_victim_select

Pseudo-random victim-way selector for set-associative structures (L1 caches, TLBs). Sits directly downstream of the `lfsr` block, which it instantiates internally. It turns the raw LFSR value into a legal replacement way: it skips locked ways, optionally prefers invalid ways, and returns one registered victim per request over a ready/valid-style handshake.

## Interface
- `WAYS`, default 4: number of ways; power of two, 4–64.
- `NEEDS_RESET`, default 1: passed to the internal `lfsr`. When 0, the LFSR is not cleared by `rst`.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `req` in 1: victim request. Accepted when `req & ready`.
- `valid_ways` in WAYS: per-way valid bits of the target set. Sampled on accept.
- `locked_ways` in WAYS: per-way lock bits; locked ways are never chosen. Sampled on accept.
- `ready` out 1: high only in IDLE.
- `victim_valid` out 1: one-cycle response pulse.
- `victim_none` out 1: qualifies `victim_valid`; high when every way was locked.
- `victim_way` out $clog2(WAYS): chosen way index.
- `victim_oh` out WAYS: one-hot of `victim_way`; all zeros when `victim_none`.

## Operation
- Internal `lfsr` instance:
  - WIDTH = $clog2(WAYS), which gives the full 2^WIDTH sequence including all-ones.
  - `en` = `req & ready`, so the LFSR steps exactly once per accepted request.
- Candidate = current LFSR value in the accept cycle, i.e. before the step.
- FSM states: IDLE, SEARCH, RESPOND.
- On accept in IDLE, using the sampled masks (checked in this order):
  - All ways locked → RESPOND with `victim_none`=1, `victim_way`=0, `victim_oh`=0.
  - Invalid-first enabled (see Configuration) and any way is invalid and unlocked → RESPOND with the lowest such index.
  - Candidate unlocked → RESPOND with the candidate.
  - Otherwise → SEARCH with candidate+1 (mod WAYS).
- SEARCH: each cycle tests the current index against the sampled lock mask.
  - Unlocked → RESPOND with that index.
  - Locked → index+1, wrapping WAYS-1 → 0.
  - Terminates in at most WAYS-1 cycles, because the all-locked case is excluded at accept.
- RESPOND:
  - `victim_valid`=1 for exactly this cycle; outputs are registered and stable.
  - Next state IDLE unconditionally.
- Changes on `valid_ways`/`locked_ways` after accept are ignored.
- `req` while `ready`=0 is not accepted and does not step the LFSR.
- Reset values: state IDLE; `ready`=1 in the first cycle after reset; `victim_valid`=0, `victim_none`=0, `victim_way`=0, `victim_oh`=0; LFSR=0 when NEEDS_RESET=1.
- Reset mid-SEARCH or mid-RESPOND: the request is dropped, there is no response, and the block returns to IDLE.

## Timing
- Accept at cycle t.
- Direct hit (no search): `victim_valid` at t+1, `ready` again at t+2.
- k search steps: `victim_valid` at t+1+k.
- Peak throughput: one request per 2 cycles.
- `ready` is a function of state only; no combinational path from `req`.

## Configuration
- `LFSR_VICTIM_INVALID_FIRST_EN` defined: invalid unlocked ways take priority over the LFSR candidate (lowest index wins). The LFSR still steps on that accept.
- Not defined: `valid_ways` is ignored. Selection is purely LFSR plus lock skip, and the invalid-way priority logic is not built.

## Test plan
- WAYS=4, reset, no locks, all valid, two back-to-back requests → `victim_way`=0 then 1. The LFSR goes 00→01 because width-2 feedback is ~value[1]. Second `victim_valid` is 2 cycles after the first.
- WAYS=4, macro undefined, 16 accepted requests with no locks → the victim sequence equals an LFSR reference model. All 4 ways appear, 4 times each.
- WAYS=4, first request after reset with `locked_ways`=4'b0011 → 2 SEARCH cycles, `victim_way`=2, `victim_valid` at t+3.
- WAYS=8, `locked_ways`=8'hFF → t+1 `victim_valid`=1, `victim_none`=1, `victim_oh`=0.
- Macro defined, WAYS=8, `valid_ways`=8'hF3, `locked_ways`=8'h04 → `victim_way`=3 at t+1. Repeating with the macro undefined returns the LFSR candidate.
- `rst` asserted during SEARCH (`locked_ways`=8'h7F, WAYS=8) → no `victim_valid`, `ready`=1 next cycle, LFSR=0. A toggling `locked_ways` mid-search does not change the result.
